// File: rtl/bram_sdp_be.sv
// Simple-dual-port RAM: byte-enabled write port, independent read port, built-in zero-clear engine.
// Latency: read data and rd_valid appear RD_LATENCY cycles after the rd_n strobe edge (1 or 2).
// Backpressure: none; reads and writes during a clear are dropped and busy is high for the clear.
module bram_sdp_be #(
    parameter int BRAM_ADDR_WIDTH = 9,
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int RD_LATENCY      = 1,
    parameter int RDW_MODE        = 0,
    parameter int CLEAR_ON_RESET  = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_n,
    input  logic [BRAM_ADDR_WIDTH-1:0]   wr_addr,
    input  logic [BRAM_DATA_WIDTH/8-1:0] wr_be,
    input  logic [BRAM_DATA_WIDTH-1:0]   wr_data,
    input  logic                         rd_n,
    input  logic [BRAM_ADDR_WIDTH-1:0]   rd_addr,
    output logic [BRAM_DATA_WIDTH-1:0]   rd_data,
    output logic                         rd_valid,
    input  logic                         clr_n,
    output logic                         busy
);

    localparam int DEPTH     = 1 << BRAM_ADDR_WIDTH;
    localparam int NUM_BYTES = BRAM_DATA_WIDTH / 8;

    // Reject parameter sets the read pipeline and byte lanes cannot represent.
    if (!(RD_LATENCY == 1 || RD_LATENCY == 2) ||
        (BRAM_DATA_WIDTH % 8) != 0 || BRAM_DATA_WIDTH < 8) begin : g_bad_params
        $fatal(1, "bram_sdp_be: illegal RD_LATENCY or BRAM_DATA_WIDTH");
    end

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    state_t                       state_q, state_d;
    logic [BRAM_ADDR_WIDTH-1:0]   cnt_q, cnt_d;

    logic [BRAM_DATA_WIDTH-1:0]   mem [DEPTH];

    logic                         wr_en;
    logic                         rd_en;
    logic                         clr_we;
    logic [BRAM_DATA_WIDTH-1:0]   rd_word;

    logic                         s1_vld_q;
    logic [BRAM_DATA_WIDTH-1:0]   s1_dat_q;

    // Host accesses only reach the array while the clear engine is parked.
    assign wr_en  = (state_q == ST_IDLE) && !wr_n;
    assign rd_en  = (state_q == ST_IDLE) && !rd_n;
    assign clr_we = (state_q == ST_CLEAR);
    assign busy   = (state_q == ST_CLEAR);

    // State and clear-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Clear engine: walk every address once, then fall back to IDLE; clr_n is ignored mid-clear.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (!clr_n) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {BRAM_ADDR_WIDTH{1'b1}}) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Array write port: the clear engine owns it while running, otherwise byte-enabled host writes.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Read word; in new-data mode, same-address enabled write bytes are forwarded over the stored word.
    always_comb begin
        rd_word = mem[rd_addr];
        if (RDW_MODE == 1 && wr_en && (wr_addr == rd_addr)) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (wr_be[i]) begin
                    rd_word[8*i +: 8] = wr_data[8*i +: 8];
                end
            end
        end
    end

    // First read stage: data only moves on an accepted read so it holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_dat_q <= '0;
        end else begin
            s1_vld_q <= rd_en;
            if (rd_en) begin
                s1_dat_q <= rd_word;
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic                       s2_vld_q;
        logic [BRAM_DATA_WIDTH-1:0] s2_dat_q;

        // Second read stage: forwards each completed first-stage read one cycle later.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_vld_q <= 1'b0;
                s2_dat_q <= '0;
            end else begin
                s2_vld_q <= s1_vld_q;
                if (s1_vld_q) begin
                    s2_dat_q <= s1_dat_q;
                end
            end
        end

        assign rd_data  = s2_dat_q;
        assign rd_valid = s2_vld_q;
    end else begin : g_lat1
        assign rd_data  = s1_dat_q;
        assign rd_valid = s1_vld_q;
    end

endmodule

// File: tb/tb_bram_sdp_be.sv
module tb_bram_sdp_be;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic        clk;
    logic        rst_n;
    logic        wr_n;
    logic [3:0]  wr_addr;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        rd_n;
    logic [3:0]  rd_addr;
    logic        clr_n;

    logic [31:0] rd_data0, rd_data1;
    logic        rd_valid0, rd_valid1;
    logic        busy0, busy1;

    // dut0: latency 1, old-data; dut1: latency 2, new-data. Both see identical stimulus.
    bram_sdp_be #(.BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(32), .RD_LATENCY(1),
                  .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_n(wr_n), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_n(rd_n), .rd_addr(rd_addr), .rd_data(rd_data0),
        .rd_valid(rd_valid0), .clr_n(clr_n), .busy(busy0));

    bram_sdp_be #(.BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(32), .RD_LATENCY(2),
                  .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_n(wr_n), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .rd_n(rd_n), .rd_addr(rd_addr), .rd_data(rd_data1),
        .rd_valid(rd_valid1), .clr_n(clr_n), .busy(busy1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          c;
        logic [31:0] d;
    } ev_t;

    logic [31:0] mem_m [DEPTH];
    ev_t         q0[$];
    ev_t         q1[$];
    logic [31:0] last0 = '0;
    logic [31:0] last1 = '0;
    bit          busy_m = 1'b1;
    int          clr_left = DEPTH;
    int          cyc = 0;
    int          vcnt0 = 0;
    int          vcnt1 = 0;

    always @(negedge rst_n) begin
        q0.delete();
        q1.delete();
        last0    = '0;
        last1    = '0;
        busy_m   = 1'b1;
        clr_left = DEPTH;
    end

    always @(posedge clk) begin
        logic [31:0] rv, rvn;
        cyc++;
        if (rst_n) begin
            if (!busy_m) begin
                if (!rd_n) begin
                    rv  = mem_m[rd_addr];
                    rvn = rv;
                    if (!wr_n && wr_addr == rd_addr)
                        for (int b = 0; b < 4; b++)
                            if (wr_be[b]) rvn[8*b +: 8] = wr_data[8*b +: 8];
                    q0.push_back('{cyc, rv});
                    q1.push_back('{cyc + 1, rvn});
                end
                if (!wr_n)
                    for (int b = 0; b < 4; b++)
                        if (wr_be[b]) mem_m[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
                if (!clr_n) begin
                    busy_m   = 1'b1;
                    clr_left = DEPTH;
                end
            end else begin
                clr_left--;
                if (clr_left == 0) begin
                    for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
                    busy_m = 1'b0;
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        bit e0, e1;
        e0 = (q0.size() > 0) && (q0[0].c == cyc);
        e1 = (q1.size() > 0) && (q1[0].c == cyc);
        if (e0) begin last0 = q0[0].d; void'(q0.pop_front()); end
        if (e1) begin last1 = q1[0].d; void'(q1.pop_front()); end
        if (rd_valid0 === 1'b1) vcnt0++;
        if (rd_valid1 === 1'b1) vcnt1++;
        chk("busy0",     {31'b0, busy0},     {31'b0, busy_m});
        chk("busy1",     {31'b0, busy1},     {31'b0, busy_m});
        chk("rd_valid0", {31'b0, rd_valid0}, {31'b0, e0});
        chk("rd_valid1", {31'b0, rd_valid1}, {31'b0, e1});
        chk("rd_data0",  rd_data0, last0);
        chk("rd_data1",  rd_data1, last1);
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        wr_n  = 1'b1;
        rd_n  = 1'b1;
        clr_n = 1'b1;
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_n = 1'b0; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        idle();
    endtask

    // Counts cycles busy stays high, starting from the current (busy) cycle.
    task automatic count_busy(input string name);
        int n = 0;
        while (busy0 === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        chk(name, n, DEPTH);
    endtask

    initial begin
        int s0, s1;
        idle();
        wr_addr = '0; wr_data = '0; wr_be = '0; rd_addr = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        tick(3);
        chk("reset_busy",   {31'b0, busy0},     32'd1);
        chk("reset_valid",  {31'b0, rd_valid1}, 32'd0);
        chk("reset_data",   rd_data1,           32'd0);

        // Auto-clear after reset release.
        rst_n = 1'b1;
        count_busy("auto_clear_cycles");
        tick(2);

        // Every address reads zero with one rd_valid each.
        s0 = vcnt0; s1 = vcnt1;
        for (int i = 0; i < DEPTH; i++) begin
            rd_n = 1'b0; rd_addr = 4'(i);
            tick();
        end
        idle();
        tick(3);
        chk("clr_reads_valid0", 32'(vcnt0 - s0), 32'd16);
        chk("clr_reads_valid1", 32'(vcnt1 - s1), 32'd16);

        // Byte enables.
        wr(4'd5, 32'hAABBCCDD, 4'hF);
        wr(4'd5, 32'h11223344, 4'b0101);
        rd_n = 1'b0; rd_addr = 4'd5;
        tick();
        idle();
        chk("be_merge_lat1", rd_data0, 32'hAA22CC44);
        tick();
        chk("be_merge_lat2", rd_data1, 32'hAA22CC44);
        tick(2);

        // Back-to-back reads of 1,2,3.
        wr(4'd1, 32'h0000_1111, 4'hF);
        wr(4'd2, 32'h0000_2222, 4'hF);
        wr(4'd3, 32'h0000_3333, 4'hF);
        for (int i = 1; i <= 3; i++) begin
            rd_n = 1'b0; rd_addr = 4'(i);
            tick();
        end
        idle();
        chk("b2b_lat1_last", rd_data0, 32'h0000_3333);
        chk("b2b_lat2_first", {31'b0, rd_valid1}, 32'd1);
        tick();
        tick();
        chk("b2b_lat2_last", rd_data1, 32'h0000_3333);
        tick(2);

        // Read-during-write at the same address.
        wr(4'd7, 32'h0, 4'hF);
        wr_n = 1'b0; wr_addr = 4'd7; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
        rd_n = 1'b0; rd_addr = 4'd7;
        tick();
        idle();
        chk("rdw_old", rd_data0, 32'h0);
        tick();
        chk("rdw_new", rd_data1, 32'hFFFFFFFF);
        tick(2);

        // Clear request with a simultaneous write; accesses during busy are ignored.
        clr_n = 1'b0; wr_n = 1'b0; wr_addr = 4'd3; wr_data = 32'h12345678; wr_be = 4'hF;
        tick();
        idle();
        s0 = vcnt0; s1 = vcnt1;
        for (int i = 0; i < 12; i++) begin
            wr_n = 1'b0; wr_addr = 4'(i); wr_data = 32'hDEAD0000 + 32'(i); wr_be = 4'hF;
            rd_n = 1'b0; rd_addr = 4'(i);
            clr_n = 1'b0;
            tick();
        end
        idle();
        tick(6);
        chk("clear_drops_reads0", 32'(vcnt0 - s0), 32'd0);
        chk("clear_drops_reads1", 32'(vcnt1 - s1), 32'd0);
        rd_n = 1'b0; rd_addr = 4'd3;
        tick();
        idle();
        chk("clear_wiped_addr3", rd_data0, 32'h0);
        tick(3);

        // Randomised traffic with occasional clears.
        for (int i = 0; i < 400; i++) begin
            wr_n    = 1'($urandom_range(0, 1));
            wr_addr = 4'($urandom_range(0, 15));
            wr_be   = 4'($urandom_range(0, 15));
            wr_data = $urandom;
            rd_n    = 1'($urandom_range(0, 1));
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
            clr_n   = ($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        idle();
        tick(DEPTH + 4);

        // Reset with a read still in the latency-2 pipeline.
        s0 = vcnt0; s1 = vcnt1;
        rd_n = 1'b0; rd_addr = 4'd5; clr_n = 1'b0;
        tick();
        idle();
        #2 rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        count_busy("reset_inflight_clear_cycles");
        tick(3);
        chk("inflight_lat1_done", 32'(vcnt0 - s0), 32'd1);
        chk("inflight_lat2_flushed", 32'(vcnt1 - s1), 32'd0);

        // Reset halfway through a clear.
        clr_n = 1'b0;
        tick();
        idle();
        tick(7);
        rd_n = 1'b0; rd_addr = 4'd2;
        tick();
        idle();
        #2 rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        count_busy("reset_midclear_cycles");
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bram_sdp_be.md
Name: bram_sdp_be

Overview:
Parameterised simple-dual-port block RAM, the successor to the single-port 8-bit bram. It has one write port with per-byte write enables and one independent read port. Read latency and read-during-write behaviour are selectable by parameter. A built-in clear engine zeroes the whole array after reset or on request. It serves as general on-chip buffer and register-file storage.

Parameters:
BRAM_ADDR_WIDTH, 9, address bits; DEPTH = 1<<BRAM_ADDR_WIDTH words.
BRAM_DATA_WIDTH, 32, word width; must be a multiple of 8; NUM_BYTES = BRAM_DATA_WIDTH/8.
RD_LATENCY, 1, read latency in cycles; legal values 1 or 2.
RDW_MODE, 0, same-address read-during-write result; 0 = old data, 1 = new (merged) data.
CLEAR_ON_RESET, 1, when 1, a full clear runs automatically after reset deasserts.

Ports:
clk  in  1  clock; all logic on posedge.
rst_n  in  1  asynchronous reset, active-low.
wr_n  in  1  write strobe, active-low.
wr_addr  in  BRAM_ADDR_WIDTH  write address.
wr_be  in  NUM_BYTES  byte enables, active-high; bit i covers data[8i+7:8i].
wr_data  in  BRAM_DATA_WIDTH  write data.
rd_n  in  1  read strobe, active-low.
rd_addr  in  BRAM_ADDR_WIDTH  read address.
rd_data  out  BRAM_DATA_WIDTH  registered read data.
rd_valid  out  1  one-cycle pulse marking new rd_data.
clr_n  in  1  clear request, active-low, level-sampled.
busy  out  1  high while the clear engine runs.

Behaviour:
- Reset (rst_n=0, async):
  - rd_data=0, rd_valid=0, all read pipeline registers and valid bits 0.
  - Clear counter = 0.
  - State = CLEAR and busy=1 if CLEAR_ON_RESET=1; otherwise state = IDLE and busy=0.
  - Memory contents are not touched by reset itself.
- FSM, two states:
  - IDLE -> CLEAR when clr_n=0 is sampled in IDLE.
  - CLEAR writes 0 to mem[cnt] each cycle, then cnt++. After writing DEPTH-1: cnt returns to 0 and the FSM returns to IDLE.
  - A clear takes exactly DEPTH cycles. busy is high exactly for the cycles the state is CLEAR.
  - clr_n is ignored while in CLEAR; there is no restart.
- Write (IDLE only): on posedge with wr_n=0, for each i with wr_be[i]=1, mem[wr_addr] byte i <= wr_data byte i. Other bytes are unchanged. wr_be=0 is a no-op.
- Write during CLEAR is dropped silently.
- Same-cycle clr_n=0 and wr_n=0 in IDLE: the write commits; the clear starts next cycle and will overwrite it.
- Read (IDLE only):
  - rd_n=0 sampled at edge N -> rd_data updated and rd_valid=1 after edge N+RD_LATENCY-1. Read data is therefore visible one cycle after the strobe for RD_LATENCY=1, two cycles after for RD_LATENCY=2.
  - Fully pipelined: one read per cycle, with one rd_valid pulse per accepted read.
  - rd_data holds its last value when no read completes.
- Read during CLEAR is dropped: no rd_valid. Reads already in the pipeline when a clear starts still complete.
- Same-address read and write in one cycle:
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the merged word (enabled bytes from wr_data, the rest from mem).
  - Different addresses do not interact.
- Reset mid-clear or mid-read: the pipeline is flushed (no late rd_valid), and the counter and state reload per the reset rules above.
- Illegal parameters (RD_LATENCY not 1 or 2, or a width not a multiple of 8) are a fatal elaboration error.

Test Plan:
- CLEAR_ON_RESET=1, ADDR_WIDTH=4: release rst_n -> busy high exactly 16 cycles; reads of all 16 addresses then return 0x00000000 with one rd_valid each.
- Byte enables: write 0xAABBCCDD to addr 5 with be=4'hF, then 0x11223344 with be=4'b0101 -> read addr 5 returns 0xAA22CC44.
- RD_LATENCY=2, back-to-back reads of addr 1,2,3 -> rd_valid high for 3 consecutive cycles starting 2 cycles after the first strobe; data in order.
- RDW: mem[7]=0x0, same-cycle write 0xFFFFFFFF (be=4'hF) and read of addr 7 -> RDW_MODE=0 returns 0x0; RDW_MODE=1 returns 0xFFFFFFFF.
- clr_n pulse with simultaneous write of 0x12345678 to addr 3 -> busy for DEPTH cycles; during busy, write and read strobes give no effect and no rd_valid; afterwards addr 3 reads 0x0.
- rst_n asserted halfway through a clear with one read in flight -> rd_valid never pulses; busy restarts at cnt=0 and the clear completes DEPTH cycles after release.
